// File: rtl/deser_pkg.sv
// Shared definitions for the deser16_rv serial word assembler:
// default word width, FSM state encoding and frame-length helper.
package deser_pkg;
  localparam int DESER_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } deser_state_e;

  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction
endpackage

// File: rtl/deser16_rv_if.sv
// Valid/ready word port between the deserializer and the parallel data register.
interface deser16_rv_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             d_ready;

  modport master (output d_out, output d_valid, input d_ready);
  modport slave  (input d_out, input d_valid, output d_ready);
endinterface

// File: rtl/deser_bit_cnt.sv
// Frame bit counter: counts strobes up to FRAME-1 and wraps; clr realigns the frame.
module deser_bit_cnt #(
  parameter int FRAME = 16,
  parameter int CW    = $clog2(FRAME + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);
  // A realign always wins, so the final bit of a frame never completes alongside clr.
  assign last = inc && !clr && (cnt == CW'(FRAME - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CW'(1) : '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/deser16_rv.sv
// Serial-to-parallel word assembler with single-entry valid/ready output buffer.
// Optional even-parity frame check is enabled with `define DESER16_PARITY_EN.
module deser16_rv
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic s_bit,
  input  logic s_valid,
  input  logic s_sync,
  deser16_rv_if.master dq,
  output logic busy,
  output logic overrun
`ifdef DESER16_PARITY_EN
  ,
  output logic parity_err
`endif
);
`ifdef DESER16_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = frame_len(WIDTH, PAR_EN);
  localparam int CW    = $clog2(FRAME + 1);

  localparam logic [0:0] IDLE  = ST_IDLE;
  localparam logic [0:0] SHIFT = ST_SHIFT;

  logic [0:0]       state, state_n;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             data_bit;
  logic             par_ok;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] sr, sr_n, word;
  logic [WIDTH-1:0] d_out_q;
  logic             d_valid_q;

  deser_bit_cnt #(.FRAME(FRAME), .CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (s_sync),
    .inc   (s_valid),
    .cnt   (cnt),
    .last  (last)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (s_valid) state_n = SHIFT;
      SHIFT: begin
        if (s_valid)     state_n = last ? IDLE : SHIFT;
        else if (s_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign sr_n = MSB_FIRST ? {sr[WIDTH-2:0], s_bit} : {s_bit, sr[WIDTH-1:1]};

  // The trailing parity bit must not disturb the assembled data bits.
  assign data_bit = PAR_EN ? (s_sync || cnt != CW'(WIDTH)) : 1'b1;
  assign word     = PAR_EN ? sr : sr_n;

`ifdef DESER16_PARITY_EN
  logic par_acc;
  assign par_ok = ~(par_acc ^ s_bit);

  always_ff @(posedge clk) begin
    if (reset) begin
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (s_valid) par_acc <= (s_sync || cnt == '0) ? s_bit : par_acc ^ s_bit;
      parity_err <= last && !par_ok;
    end
  end
`else
  assign par_ok = 1'b1;
`endif

  assign accept = last && par_ok;
  assign load   = accept && (!d_valid_q || dq.d_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_n;
      if (s_valid && data_bit) sr <= sr_n;
      if (load) d_out_q <= word;
      d_valid_q <= load || (d_valid_q && !dq.d_ready);
      if (accept && d_valid_q && !dq.d_ready) overrun <= 1'b1;
    end
  end

  assign busy       = (state == SHIFT);
  assign dq.d_out   = d_out_q;
  assign dq.d_valid = d_valid_q;
endmodule

// File: tb/tb_deser16_rv.sv
// Directed bench for deser16_rv: MSB-first and LSB-first instances share one serial stream.
module tb_deser16_rv;
  import deser_pkg::*;
`ifdef DESER16_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FR = frame_len(16, PAR);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_bit = 1'b0, s_valid = 1'b0, s_sync = 1'b0;
  logic busy_m, ovr_m, busy_l, ovr_l;
`ifdef DESER16_PARITY_EN
  logic perr_m, perr_l;
`endif
  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] f;

  always #5 clk = ~clk;

  deser16_rv_if #(.WIDTH(16)) if_m ();
  deser16_rv_if #(.WIDTH(16)) if_l ();

  deser16_rv #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .s_bit(s_bit), .s_valid(s_valid), .s_sync(s_sync),
    .dq(if_m.master), .busy(busy_m), .overrun(ovr_m)
`ifdef DESER16_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  deser16_rv #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .s_bit(s_bit), .s_valid(s_valid), .s_sync(s_sync),
    .dq(if_l.master), .busy(busy_l), .overrun(ovr_l)
`ifdef DESER16_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sync);
    s_bit   = b;
    s_valid = 1'b1;
    s_sync  = sync;
    step();
    s_valid = 1'b0;
    s_sync  = 1'b0;
  endtask

  function automatic logic [16:0] frame_of(input logic [15:0] w);
    return PAR ? {w, ^w} : {1'b0, w};
  endfunction

  task automatic send_bits(input logic [16:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(v[i], 1'b0);
  endtask

  initial begin
    if_m.d_ready = 1'b0;
    if_l.d_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_dout", 32'(if_m.d_out), 32'h0);
    check("rst_dvalid", 32'(if_m.d_valid), 32'h0);
    check("rst_busy", 32'(busy_m), 32'h0);
    check("rst_ovr", 32'(ovr_m), 32'h0);
    check("rst_busy_l", 32'(busy_l), 32'h0);

    // back-to-back word, both bit orders
    if_m.d_ready = 1'b1;
    if_l.d_ready = 1'b1;
    f = frame_of(16'hA5C3);
    send_bits(f, FR - 1, 1);
    check("t1_busy_mid", 32'(busy_m), 32'h1);
    check("t1_dvalid_pre", 32'(if_m.d_valid), 32'h0);
    send_bits(f, 0, 0);
    check("t1_dvalid", 32'(if_m.d_valid), 32'h1);
    check("t1_msb_word", 32'(if_m.d_out), 32'hA5C3);
    check("t1_lsb_word", 32'(if_l.d_out), 32'hC3A5);
    check("t1_busy_end", 32'(busy_m), 32'h0);
    step();
    check("t1_dvalid_clr", 32'(if_m.d_valid), 32'h0);

    // overrun with a stalled consumer
    if_m.d_ready = 1'b0;
    send_bits(frame_of(16'h1234), FR - 1, 0);
    check("t2_word1", 32'(if_m.d_out), 32'h1234);
    check("t2_ovr_pre", 32'(ovr_m), 32'h0);
    send_bits(frame_of(16'hBEEF), FR - 1, 0);
    check("t2_word_kept", 32'(if_m.d_out), 32'h1234);
    check("t2_ovr", 32'(ovr_m), 32'h1);
    check("t2_dvalid_held", 32'(if_m.d_valid), 32'h1);
    if_m.d_ready = 1'b1;
    step();
    if_m.d_ready = 1'b0;
    check("t2_dvalid_clr", 32'(if_m.d_valid), 32'h0);
    check("t2_ovr_sticky", 32'(ovr_m), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t2_ovr_rst", 32'(ovr_m), 32'h0);

    // accept and reload in the same cycle
    send_bits(frame_of(16'h00FF), FR - 1, 0);
    check("t3_pend", 32'(if_m.d_out), 32'h00FF);
    f = frame_of(16'hFF00);
    send_bits(f, FR - 1, 1);
    if_m.d_ready = 1'b1;
    send_bits(f, 0, 0);
    if_m.d_ready = 1'b0;
    check("t3_no_ovr", 32'(ovr_m), 32'h0);
    check("t3_word", 32'(if_m.d_out), 32'hFF00);
    check("t3_dvalid", 32'(if_m.d_valid), 32'h1);
    if_m.d_ready = 1'b1;
    step();
    check("t3_dvalid_clr", 32'(if_m.d_valid), 32'h0);

    // realign with a strobe, then realign without one
    send_bits(17'h1FFFF, 6, 0);
    check("t4_busy_partial", 32'(busy_m), 32'h1);
    f = frame_of(16'h8001);
    send_bit(f[FR-1], 1'b1);
    check("t4_busy_sync", 32'(busy_m), 32'h1);
    send_bits(f, FR - 2, 1);
    check("t4_dvalid_pre", 32'(if_m.d_valid), 32'h0);
    send_bits(f, 0, 0);
    check("t4_dvalid", 32'(if_m.d_valid), 32'h1);
    check("t4_word", 32'(if_m.d_out), 32'h8001);
    step();
    send_bits(17'h1FFFF, 4, 0);
    s_sync = 1'b1;
    step();
    s_sync = 1'b0;
    check("t4_sync_idle", 32'(busy_m), 32'h0);
    send_bits(frame_of(16'h0F0F), FR - 1, 0);
    check("t4_word2", 32'(if_m.d_out), 32'h0F0F);
    step();

    // reset mid-word with a pending word
    if_m.d_ready = 1'b0;
    send_bits(frame_of(16'h5555), FR - 1, 0);
    check("t5_pend", 32'(if_m.d_valid), 32'h1);
    send_bits(frame_of(16'h3C3C), FR - 1, FR - 9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_dout", 32'(if_m.d_out), 32'h0);
    check("t5_dvalid", 32'(if_m.d_valid), 32'h0);
    check("t5_busy", 32'(busy_m), 32'h0);
    check("t5_ovr", 32'(ovr_m), 32'h0);
    if_m.d_ready = 1'b1;
    send_bits(frame_of(16'h3C3C), FR - 1, 0);
    check("t5_fresh", 32'(if_m.d_out), 32'h3C3C);
    check("t5_fresh_valid", 32'(if_m.d_valid), 32'h1);
    step();

`ifdef DESER16_PARITY_EN
    send_bits({16'h0001, 1'b0}, 16, 0);
    check("p_drop", 32'(if_m.d_valid), 32'h0);
    check("p_err", 32'(perr_m), 32'h1);
    check("p_dout_kept", 32'(if_m.d_out), 32'h3C3C);
    step();
    check("p_err_pulse", 32'(perr_m), 32'h0);
    send_bits({16'h0001, 1'b1}, 16, 0);
    check("p_ok_valid", 32'(if_m.d_valid), 32'h1);
    check("p_ok_word", 32'(if_m.d_out), 32'h0001);
    check("p_ok_noerr", 32'(perr_m), 32'h0);
    step();
`endif

    check("lsb_no_ovr", 32'(ovr_l), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
